// File: rtl/cp0_exception_unit_pkg.sv
// Shared CP0 definitions: register numbers, exception codes, field positions
// and the default exception entry vector.
package cp0_exception_unit_pkg;

    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

    // CP0 register numbers (MFC0/MTC0 rd field)
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    // Cause.ExcCode values
    typedef enum logic [4:0] {
        EXC_INT  = 5'd0,
        EXC_ADEL = 5'd4,
        EXC_ADES = 5'd5,
        EXC_SYS  = 5'd8,
        EXC_BP   = 5'd9,
        EXC_RI   = 5'd10,
        EXC_OV   = 5'd12
    } exc_code_e;

    // Which address, if any, lands in BadVAddr
    typedef enum logic [1:0] {
        BAD_KEEP = 2'd0,
        BAD_PC   = 2'd1,
        BAD_ADDR = 2'd2
    } bad_src_e;

    // Status / Cause field positions
    localparam int STATUS_IE     = 0;
    localparam int STATUS_EXL    = 1;
    localparam int STATUS_IM_LSB = 8;
    localparam int CAUSE_BD      = 31;
    localparam int CAUSE_TI      = 30;
    localparam int CAUSE_IP_LSB  = 8;
    localparam int CAUSE_EXC_LSB = 2;

    // Status reset value (BEV=1) and MTC0-writable bits (IM, EXL, IE)
    localparam logic [31:0] STATUS_RESET = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    // Bit positions inside mem_exc_flags
    localparam int FLAG_INV  = 0;
    localparam int FLAG_OV   = 1;
    localparam int FLAG_BRK  = 2;
    localparam int FLAG_SYS  = 3;
    localparam int FLAG_ERET = 4;

    // EPC points at the branch when the faulting instruction is in its delay slot
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic in_delay);
        return in_delay ? (pc - 32'd4) : pc;
    endfunction

endpackage

// File: rtl/cp0_exception_unit_timer.sv
// CP0 timer: prescaled Count, Compare and the sticky timer-interrupt flag TI.
module cp0_timer #(
    parameter int COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_count,
    input  logic        we_compare,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        ti
);
    localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(COUNT_DIV - 1);

    logic [PW-1:0] presc_r;
    logic [31:0]   count_r;
    logic [31:0]   compare_r;
    logic          ti_r;
    logic          tick_s;

    assign tick_s = (presc_r == PRESC_LAST);

    // Count advances once per COUNT_DIV clocks; a software load restarts the prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_r <= '0;
            count_r <= 32'd0;
        end else if (we_count) begin
            presc_r <= '0;
            count_r <= wdata;
        end else if (tick_s) begin
            presc_r <= '0;
            count_r <= count_r + 32'd1;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Compare register; writing it also acknowledges the timer interrupt
    always_ff @(posedge clk) begin
        if (rst) begin
            compare_r <= 32'd0;
            ti_r      <= 1'b0;
        end else if (we_compare) begin
            compare_r <= wdata;
            ti_r      <= 1'b0;
        end else if (count_r == compare_r) begin
            ti_r      <= 1'b1;
        end
    end

    assign count   = count_r;
    assign compare = compare_r;
    assign ti      = ti_r;

endmodule

// File: rtl/cp0_exception_unit.sv
// MEM-stage precise-exception controller with the CP0 register file.
// Chooses one exception per cycle, flushes IF..MEM, redirects fetch and
// updates Status/Cause/EPC/BadVAddr; also serves MFC0 reads and MTC0 writes.
module cp0_exception_unit
    import cp0_exception_unit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          COUNT_DIV  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delay,
    input  logic [4:0]  mem_exc_flags,
    input  logic        mem_adel_if,
    input  logic        mem_adel_d,
    input  logic        mem_ades_d,
    input  logic [31:0] mem_addr,
    input  logic [5:0]  hw_int,
    input  logic        cp0_we,
    input  logic [4:0]  cp0_waddr,
    input  logic [31:0] cp0_wdata,
    input  logic [4:0]  cp0_raddr,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o
);
    logic [31:0] status_r, epc_r, badvaddr_r;
    logic [5:0]  hw_int_r;
    logic [1:0]  sw_ip_r;
    logic        bd_r;
    exc_code_e   exc_code_r;

    logic [31:0] count_s, compare_s, cause_s;
    logic        ti_s, int_pend_s, exc_take_s, eret_take_s, flush_s, cp0_wr_s;
    logic [7:0]  ip_s;
    exc_code_e   exc_code_s;
    bad_src_e    bad_src_s;

    // IP[15] also carries the timer interrupt
    assign ip_s       = {hw_int_r[5] | ti_s, hw_int_r[4:0], sw_ip_r};
    assign int_pend_s = status_r[STATUS_IE] & ~status_r[STATUS_EXL]
                      & (|(status_r[STATUS_IM_LSB +: 8] & ip_s));
    assign flush_s    = exc_take_s | eret_take_s;
    // An instruction that is being flushed must not commit its MTC0
    assign cp0_wr_s   = cp0_we & mem_valid & ~flush_s;

    cp0_timer #(.COUNT_DIV(COUNT_DIV)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .we_count   (cp0_wr_s & (cp0_waddr == CP0_COUNT)),
        .we_compare (cp0_wr_s & (cp0_waddr == CP0_COMPARE)),
        .wdata      (cp0_wdata),
        .count      (count_s),
        .compare    (compare_s),
        .ti         (ti_s)
    );

    // Priority encoder: one exception (or ERET) for the instruction in MEM
    always_comb begin
        exc_take_s  = 1'b0;
        eret_take_s = 1'b0;
        exc_code_s  = EXC_INT;
        bad_src_s   = BAD_KEEP;
        if (rst || !mem_valid) begin
            exc_take_s = 1'b0;
        end else if (int_pend_s) begin
            exc_take_s = 1'b1;
            exc_code_s = EXC_INT;
        end else if (mem_adel_if) begin
            exc_take_s = 1'b1;
            exc_code_s = EXC_ADEL;
            bad_src_s  = BAD_PC;
        end else if (mem_exc_flags[FLAG_INV]) begin
            exc_take_s = 1'b1;
            exc_code_s = EXC_RI;
        end else if (mem_exc_flags[FLAG_OV]) begin
            exc_take_s = 1'b1;
            exc_code_s = EXC_OV;
        end else if (mem_exc_flags[FLAG_SYS]) begin
            exc_take_s = 1'b1;
            exc_code_s = EXC_SYS;
        end else if (mem_exc_flags[FLAG_BRK]) begin
            exc_take_s = 1'b1;
            exc_code_s = EXC_BP;
        end else if (mem_adel_d) begin
            exc_take_s = 1'b1;
            exc_code_s = EXC_ADEL;
            bad_src_s  = BAD_ADDR;
        end else if (mem_ades_d) begin
            exc_take_s = 1'b1;
            exc_code_s = EXC_ADES;
            bad_src_s  = BAD_ADDR;
        end else if (mem_exc_flags[FLAG_ERET]) begin
            eret_take_s = 1'b1;
        end else begin
            eret_take_s = 1'b0;
        end
    end

    // Fetch redirect target for the current flush
    always_comb begin
        redirect_pc = 32'd0;
        if (exc_take_s) begin
            redirect_pc = EXC_VECTOR;
        end else if (eret_take_s) begin
            redirect_pc = epc_r;
        end else begin
            redirect_pc = 32'd0;
        end
    end

    // Level-sensitive external interrupt lines sampled into Cause.IP[15:10]
    always_ff @(posedge clk) begin
        if (rst) begin
            hw_int_r <= 6'd0;
        end else begin
            hw_int_r <= hw_int;
        end
    end

    // Status/Cause/EPC/BadVAddr: exception entry beats ERET beats MTC0
    always_ff @(posedge clk) begin
        if (rst) begin
            status_r   <= STATUS_RESET;
            epc_r      <= 32'd0;
            badvaddr_r <= 32'd0;
            bd_r       <= 1'b0;
            sw_ip_r    <= 2'd0;
            exc_code_r <= EXC_INT;
        end else if (exc_take_s) begin
            exc_code_r           <= exc_code_s;
            status_r[STATUS_EXL] <= 1'b1;
            // Nested exceptions keep the EPC/BD of the outermost one
            if (!status_r[STATUS_EXL]) begin
                epc_r <= epc_of(mem_pc, mem_in_delay);
                bd_r  <= mem_in_delay;
            end
            case (bad_src_s)
                BAD_PC:   badvaddr_r <= mem_pc;
                BAD_ADDR: badvaddr_r <= mem_addr;
                default:  badvaddr_r <= badvaddr_r;
            endcase
        end else if (eret_take_s) begin
            status_r[STATUS_EXL] <= 1'b0;
        end else if (cp0_wr_s) begin
            case (cp0_waddr)
                CP0_STATUS: status_r <= (status_r & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
                CP0_CAUSE:  sw_ip_r  <= cp0_wdata[CAUSE_IP_LSB +: 2];
                CP0_EPC:    epc_r    <= cp0_wdata;
                default:    sw_ip_r  <= sw_ip_r;
            endcase
        end
    end

    // Cause assembled from its live fields
    always_comb begin
        cause_s                         = 32'd0;
        cause_s[CAUSE_BD]               = bd_r;
        cause_s[CAUSE_TI]               = ti_s;
        cause_s[CAUSE_IP_LSB +: 8]      = ip_s;
        cause_s[CAUSE_EXC_LSB +: 5]     = exc_code_r;
    end

    // MFC0 read mux; unmapped registers read as zero
    always_comb begin
        cp0_rdata = 32'd0;
        case (cp0_raddr)
            CP0_BADVADDR: cp0_rdata = badvaddr_r;
            CP0_COUNT:    cp0_rdata = count_s;
            CP0_COMPARE:  cp0_rdata = compare_s;
            CP0_STATUS:   cp0_rdata = status_r;
            CP0_CAUSE:    cp0_rdata = cause_s;
            CP0_EPC:      cp0_rdata = epc_r;
            default:      cp0_rdata = 32'd0;
        endcase
    end

    assign flush    = flush_s;
    assign status_o = status_r;
    assign cause_o  = cause_s;
    assign epc_o    = epc_r;

endmodule

// File: tb/tb_cp0_exception_unit.sv
// Self-checking bench for cp0_exception_unit: directed scenarios followed by
// randomized traffic, every cycle compared against a behavioural CP0 model.
module tb_cp0_exception_unit;
    localparam logic [31:0] VEC = 32'hBFC0_0380;
    localparam int          DIV = 2;

    logic        clk = 1'b0;
    logic        rst, mem_valid, mem_in_delay, mem_adel_if, mem_adel_d, mem_ades_d, cp0_we;
    logic [31:0] mem_pc, mem_addr, cp0_wdata;
    logic [4:0]  mem_exc_flags, cp0_waddr, cp0_raddr;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata, redirect_pc, status_o, cause_o, epc_o;
    logic        flush;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    cp0_exception_unit #(.EXC_VECTOR(VEC), .COUNT_DIV(DIV)) dut (
        .clk(clk), .rst(rst), .mem_valid(mem_valid), .mem_pc(mem_pc),
        .mem_in_delay(mem_in_delay), .mem_exc_flags(mem_exc_flags),
        .mem_adel_if(mem_adel_if), .mem_adel_d(mem_adel_d), .mem_ades_d(mem_ades_d),
        .mem_addr(mem_addr), .hw_int(hw_int), .cp0_we(cp0_we), .cp0_waddr(cp0_waddr),
        .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata),
        .flush(flush), .redirect_pc(redirect_pc), .status_o(status_o),
        .cause_o(cause_o), .epc_o(epc_o)
    );

    // ---------------- behavioural model state ----------------
    logic [7:0]  m_im;
    logic        m_exl, m_ie, m_bd, m_ti;
    logic [4:0]  m_code;
    logic [31:0] m_epc, m_bad, m_count, m_cmp;
    logic [1:0]  m_sw;
    logic [5:0]  m_hw;
    int          m_presc;
    // priority order: Int, AdEL_if, RI, Ov, Sys, Bp, AdEL_d, AdES
    int          exc_codes [8] = '{0, 4, 10, 12, 8, 9, 4, 5};
    logic [4:0]  reg_pool [8]  = '{5'd8, 5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd0, 5'd31};

    task automatic model_reset();
        m_im = 8'd0; m_exl = 1'b0; m_ie = 1'b0; m_bd = 1'b0; m_ti = 1'b0;
        m_code = 5'd0; m_epc = 32'd0; m_bad = 32'd0; m_count = 32'd0; m_cmp = 32'd0;
        m_sw = 2'd0; m_hw = 6'd0; m_presc = 0;
    endtask

    function automatic logic [7:0] m_ip();
        return {m_hw[5] | m_ti, m_hw[4:0], m_sw};
    endfunction

    function automatic logic [31:0] m_status();
        return 32'h0040_0000 | {16'd0, m_im, 6'd0, m_exl, m_ie};
    endfunction

    function automatic logic [31:0] m_cause();
        return {m_bd, m_ti, 14'd0, m_ip(), 1'b0, m_code, 2'd0};
    endfunction

    function automatic logic [31:0] m_read(input logic [4:0] a);
        case (a)
            5'd8:    return m_bad;
            5'd9:    return m_count;
            5'd11:   return m_cmp;
            5'd12:   return m_status();
            5'd13:   return m_cause();
            5'd14:   return m_epc;
            default: return 32'd0;
        endcase
    endfunction

    // index into the priority table of the exception taken now, -1 if none
    function automatic int pick_exc();
        logic [7:0] c;
        if (rst || !mem_valid) return -1;
        c[0] = m_ie && !m_exl && ((m_im & m_ip()) != 8'd0);
        c[1] = mem_adel_if;
        c[2] = mem_exc_flags[0];
        c[3] = mem_exc_flags[1];
        c[4] = mem_exc_flags[3];
        c[5] = mem_exc_flags[2];
        c[6] = mem_adel_d;
        c[7] = mem_ades_d;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // one clock: compare all outputs at the falling edge, then advance the model
    task automatic cycle();
        int   k;
        logic er, fl, wr, match;
        @(negedge clk);
        k  = pick_exc();
        er = !rst && mem_valid && mem_exc_flags[4] && (k < 0);
        fl = (k >= 0) || er;
        check("flush", {31'd0, flush}, {31'd0, fl});
        check("redirect", redirect_pc, (k >= 0) ? VEC : (er ? m_epc : 32'd0));
        check("status", status_o, m_status());
        check("cause", cause_o, m_cause());
        check("epc", epc_o, m_epc);
        check("rdata", cp0_rdata, m_read(cp0_raddr));
        @(posedge clk);
        wr = cp0_we && mem_valid && !fl;
        if (rst) begin
            model_reset();
        end else begin
            match = (m_count == m_cmp);
            if (wr && cp0_waddr == 5'd9) begin
                m_count = cp0_wdata;
                m_presc = 0;
            end else begin
                m_presc = m_presc + 1;
                if (m_presc == DIV) begin
                    m_presc = 0;
                    m_count = m_count + 32'd1;
                end
            end
            if (wr && cp0_waddr == 5'd11) begin
                m_cmp = cp0_wdata;
                m_ti  = 1'b0;
            end else if (match) begin
                m_ti = 1'b1;
            end
            if (k >= 0) begin
                m_code = 5'(exc_codes[k]);
                if (!m_exl) begin
                    m_epc = mem_in_delay ? mem_pc - 32'd4 : mem_pc;
                    m_bd  = mem_in_delay;
                end
                m_exl = 1'b1;
                if (k == 1) m_bad = mem_pc;
                else if (k >= 6) m_bad = mem_addr;
            end else if (er) begin
                m_exl = 1'b0;
            end else if (wr) begin
                case (cp0_waddr)
                    5'd12: begin m_im = cp0_wdata[15:8]; m_exl = cp0_wdata[1]; m_ie = cp0_wdata[0]; end
                    5'd13: m_sw = cp0_wdata[9:8];
                    5'd14: m_epc = cp0_wdata;
                    default: ;
                endcase
            end
            m_hw = hw_int;
        end
        #1;
    endtask

    task automatic idle();
        rst = 1'b0; mem_valid = 1'b0; mem_pc = 32'd0; mem_in_delay = 1'b0;
        mem_exc_flags = 5'd0; mem_adel_if = 1'b0; mem_adel_d = 1'b0; mem_ades_d = 1'b0;
        mem_addr = 32'd0; hw_int = 6'd0; cp0_we = 1'b0; cp0_waddr = 5'd0;
        cp0_wdata = 32'd0; cp0_raddr = 5'd0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [4:0] flags, input logic dly);
        idle();
        mem_valid = 1'b1; mem_pc = pc; mem_exc_flags = flags; mem_in_delay = dly;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        instr(32'h8000_0100, 5'd0, 1'b0);
        cp0_we = 1'b1; cp0_waddr = a; cp0_wdata = d;
    endtask

    initial begin
        int n;
        // T1 reset
        idle();
        rst = 1'b1;
        cp0_raddr = 5'd12;
        model_reset();
        @(posedge clk); #1;
        cycle();
        cycle();
        check("t1_status", status_o, 32'h0040_0000);
        check("t1_cause", cause_o, 32'd0);
        check("t1_epc", epc_o, 32'd0);
        check("t1_flush", {31'd0, flush}, 32'd0);
        check("t1_rd12", cp0_rdata, 32'h0040_0000);
        idle(); cycle();

        // T2 syscall then ERET
        instr(32'h8000_1000, 5'b01000, 1'b0); #1;
        check("t2_flush", {31'd0, flush}, 32'd1);
        check("t2_redir", redirect_pc, 32'hBFC0_0380);
        cycle(); idle();
        check("t2_epc", epc_o, 32'h8000_1000);
        check("t2_code", {27'd0, cause_o[6:2]}, 32'd8);
        check("t2_exl", {31'd0, status_o[1]}, 32'd1);
        instr(32'h8000_1234, 5'b10000, 1'b0); #1;
        check("t2_eret_redir", redirect_pc, 32'h8000_1000);
        cycle(); idle();
        check("t2_exl_clr", {31'd0, status_o[1]}, 32'd0);

        // T3 RI beats Ov, delay slot; then nested with EXL=1
        instr(32'h8000_2004, 5'b00011, 1'b1); cycle(); idle();
        check("t3_code", {27'd0, cause_o[6:2]}, 32'd10);
        check("t3_epc", epc_o, 32'h8000_2000);
        check("t3_bd", {31'd0, cause_o[31]}, 32'd1);
        instr(32'h8000_3008, 5'b00010, 1'b0); cycle(); idle();
        check("t3_nest_code", {27'd0, cause_o[6:2]}, 32'd12);
        check("t3_nest_epc", epc_o, 32'h8000_2000);
        instr(32'h8000_0000, 5'b10000, 1'b0); cycle(); idle();

        // T4 timer interrupt
        mtc0(5'd9, 32'd0); cycle();
        mtc0(5'd11, 32'd5); cycle(); idle();
        n = 0;
        while (cause_o[30] !== 1'b1 && n < 40) begin
            cycle();
            n++;
        end
        check("t4_ti", {31'd0, cause_o[30]}, 32'd1);
        check("t4_ip7", {31'd0, cause_o[15]}, 32'd1);
        mtc0(5'd12, 32'h0000_8001); cycle();
        instr(32'h8000_5000, 5'd0, 1'b0); #1;
        check("t4_int_flush", {31'd0, flush}, 32'd1);
        cycle(); idle();
        check("t4_int_code", {27'd0, cause_o[6:2]}, 32'd0);
        check("t4_int_epc", epc_o, 32'h8000_5000);
        mtc0(5'd11, 32'hFFFF_0000); cycle(); idle();
        check("t4_ti_clr", {31'd0, cause_o[30]}, 32'd0);
        instr(32'h8000_0000, 5'b10000, 1'b0); cycle(); idle();

        // T5 misaligned load, then the same flags with mem_valid=0
        instr(32'h8000_6000, 5'd0, 1'b0);
        mem_adel_d = 1'b1; mem_addr = 32'h8000_0003; cycle(); idle();
        check("t5_code", {27'd0, cause_o[6:2]}, 32'd4);
        cp0_raddr = 5'd8; #1;
        check("t5_bad", cp0_rdata, 32'h8000_0003);
        mem_adel_d = 1'b1; mem_addr = 32'h8000_0007; #1;
        check("t5_bubble_flush", {31'd0, flush}, 32'd0);
        cycle();
        check("t5_bubble_bad", cp0_rdata, 32'h8000_0003);
        instr(32'h8000_0000, 5'b10000, 1'b0); cycle(); idle();

        // T6 MTC0 in an excepting instruction, then Cause write
        instr(32'h8000_4000, 5'b01000, 1'b0);
        cp0_we = 1'b1; cp0_waddr = 5'd14; cp0_wdata = 32'h0000_1234; cycle(); idle();
        check("t6_epc_kept", epc_o, 32'h8000_4000);
        instr(32'h8000_0000, 5'b10000, 1'b0); cycle();
        mtc0(5'd13, 32'hFFFF_FFFF); cycle(); idle();
        check("t6_cause_wr", cause_o, 32'h0000_0320);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            idle();
            rst           = ($urandom_range(0, 63) == 0);
            mem_valid     = ($urandom_range(0, 3) != 0);
            mem_pc        = $urandom;
            mem_in_delay  = 1'($urandom);
            mem_exc_flags = 5'($urandom) & 5'($urandom) & 5'($urandom);
            mem_adel_if   = ($urandom_range(0, 15) == 0);
            mem_adel_d    = ($urandom_range(0, 15) == 0);
            mem_ades_d    = ($urandom_range(0, 15) == 0);
            mem_addr      = $urandom;
            hw_int        = ($urandom_range(0, 7) == 0) ? 6'($urandom) : 6'd0;
            cp0_we        = !mem_exc_flags[4] && mem_valid && ($urandom_range(0, 2) == 0);
            cp0_waddr     = reg_pool[$urandom_range(0, 7)];
            cp0_wdata     = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) : $urandom;
            cp0_raddr     = reg_pool[$urandom_range(0, 7)];
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
